// File: rtl/nibble_serializer_fifo.sv
// Byte FIFO feeding a two-nibble serializer with valid/ready handshakes on both sides.
// Optional sticky overflow flag `ovf` is built in when NIBBLE_SER_OVF_EN is defined.
module nibble_serializer_fifo #(
   parameter int         DEPTH       = 4,
   parameter int         AW          = 2,
   parameter bit         MSB_FIRST   = 1'b1,
   parameter logic [3:0] IDLE_NIBBLE = 4'b0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [3:0]    d_out,
   output logic          d_valid,
   input  logic          out_ready,
`ifdef NIBBLE_SER_OVF_EN
   output logic          ovf,
`endif
   output logic [AW:0]   level
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FIRST  = 2'd1,
      S_SECOND = 2'd2
   } state_t;

   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   state_t        state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   level_q, level_d;
   logic [7:0]    byte_q, byte_d;
   logic [3:0]    d_out_q, d_out_d;
   logic          d_valid_q, d_valid_d;
   logic [7:0]    mem_q [DEPTH];
   logic          wr_s;
   logic          pop_s;

   function automatic logic [3:0] first_nib(input logic [7:0] b);
      if (MSB_FIRST) return b[7:4];
      else           return b[3:0];
   endfunction

   function automatic logic [3:0] second_nib(input logic [7:0] b);
      if (MSB_FIRST) return b[3:0];
      else           return b[7:4];
   endfunction

   // in_ready is a plain level compare, so a full FIFO refuses even when a pop coincides.
   assign in_ready = (level_q < DEPTH_L);
   assign wr_s     = in_valid && in_ready;
   assign d_out    = d_out_q;
   assign d_valid  = d_valid_q;
   assign level    = level_q;

   // Output FSM: one pop per byte, two nibbles per byte, no bubble between bytes.
   always_comb begin
      state_d   = state_q;
      byte_d    = byte_q;
      d_out_d   = d_out_q;
      d_valid_d = d_valid_q;
      pop_s     = 1'b0;
      case (state_q)
         S_IDLE: begin
            d_out_d   = IDLE_NIBBLE;
            d_valid_d = 1'b0;
            if (level_q != '0) begin
               pop_s     = 1'b1;
               byte_d    = mem_q[rptr_q];
               d_out_d   = first_nib(mem_q[rptr_q]);
               d_valid_d = 1'b1;
               state_d   = S_FIRST;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_FIRST: begin
            if (out_ready) begin
               d_out_d = second_nib(byte_q);
               state_d = S_SECOND;
            end else begin
               state_d = S_FIRST;
            end
         end
         S_SECOND: begin
            if (out_ready && (level_q != '0)) begin
               pop_s     = 1'b1;
               byte_d    = mem_q[rptr_q];
               d_out_d   = first_nib(mem_q[rptr_q]);
               d_valid_d = 1'b1;
               state_d   = S_FIRST;
            end else if (out_ready) begin
               d_out_d   = IDLE_NIBBLE;
               d_valid_d = 1'b0;
               state_d   = S_IDLE;
            end else begin
               state_d   = S_SECOND;
            end
         end
         default: begin
            d_out_d   = IDLE_NIBBLE;
            d_valid_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   // Pointer and occupancy bookkeeping.
   always_comb begin
      wptr_d  = wr_s  ? (wptr_q + PTR_ONE) : wptr_q;
      rptr_d  = pop_s ? (rptr_q + PTR_ONE) : rptr_q;
      case ({wr_s, pop_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         byte_q    <= 8'h00;
         d_out_q   <= IDLE_NIBBLE;
         d_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         level_q   <= level_d;
         byte_q    <= byte_d;
         d_out_q   <= d_out_d;
         d_valid_q <= d_valid_d;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      end else if (wr_s) begin
         mem_q[wptr_q] <= in_data;
      end else begin
         mem_q[wptr_q] <= mem_q[wptr_q];
      end
   end

`ifdef NIBBLE_SER_OVF_EN
   logic ovf_q;
   assign ovf = ovf_q;

   // Sticky flag: any write attempt against a full FIFO, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (in_valid && (level_q == DEPTH_L)) begin
         ovf_q <= 1'b1;
      end else begin
         ovf_q <= ovf_q;
      end
   end
`endif

endmodule

// File: doc/nibble_serializer_fifo.md
Name: nibble_serializer_fifo

Overview:
- Upstream feeder for the odd/even nibble counter stage.
- Accepts bytes over a valid/ready interface and buffers them in a small FIFO.
- Emits each byte as two consecutive 4-bit nibbles on d_out with a d_valid/out_ready handshake.
- When no data is available it drives a fixed idle nibble, so the downstream 4-bit data input is never undefined.

Parameters:
- DEPTH, 4: FIFO depth in bytes; power of 2, minimum 2.
- AW, 2: pointer width, log2(DEPTH).
- MSB_FIRST, 1: 1 = high nibble first; 0 = low nibble first.
- IDLE_NIBBLE, 4'b0000: value on d_out while d_valid=0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  byte to serialize.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; combinational, equals (level < DEPTH).
- d_out  output  4  current nibble, registered.
- d_valid  output  1  d_out holds a real nibble, registered.
- out_ready  input  1  downstream accepts d_out this cycle; tie to 1 when feeding a free-running consumer.
- level  output  AW+1  bytes held in the FIFO, excluding the byte in the output stage; registered.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: level=0, read and write pointers=0, FSM=S_IDLE, d_out=IDLE_NIBBLE, d_valid=0. in_ready therefore reads 1.
- Write: occurs when in_valid && in_ready at a rising edge. Byte goes to mem[wptr]; wptr increments and wraps mod DEPTH.
- Pop: moves mem[rptr] into the output byte register; rptr wraps mod DEPTH.
- Output FSM, one pop per byte:
  - S_IDLE: d_valid=0, d_out=IDLE_NIBBLE. If level>0 → pop, go to S_FIRST, d_out=first nibble, d_valid=1.
  - S_FIRST: if out_ready → S_SECOND, d_out=second nibble. Else hold.
  - S_SECOND: if out_ready and level>0 → pop, S_FIRST with the next byte's first nibble (no bubble). If out_ready and level=0 → S_IDLE. Else hold.
- Nibble order: first nibble is byte[7:4] when MSB_FIRST=1, else byte[3:0].
- Latency: a byte written at edge k into an empty FIFO with FSM in S_IDLE gives d_valid=1 after edge k+1. The second nibble follows after edge k+2 when out_ready=1.
- Throughput: one byte per 2 cycles sustained.
- Level arithmetic: write alone +1; pop alone −1; write and pop in the same cycle leave level unchanged.
- Full boundary: in_ready is not look-ahead. At level=DEPTH the write is refused even if a pop occurs the same cycle.
- Empty boundary: a pop is never issued at level=0. A byte written while the FSM is in S_IDLE is popped on the next edge, not the same edge.
- Backpressure: while out_ready=0, d_out, d_valid and the FSM state hold stable. FIFO writes continue until full.
- Reset mid-operation: all buffered and in-flight bytes are discarded immediately (asynchronous). Outputs return to reset values before the next edge.
- X-safety: d_out never carries uninitialised FIFO contents; only popped bytes or IDLE_NIBBLE.

Optional Feature:
- Macro: NIBBLE_SER_OVF_EN.
- Defined:
  - Adds output ovf (1 bit, registered, sticky).
  - A write attempt (in_valid=1) while level=DEPTH sets ovf=1; the byte is dropped.
  - ovf is cleared only by rst; reset value 0.
  - in_ready behaviour is unchanged.
- Not defined:
  - No ovf port.
  - Writes at level=DEPTH are simply not accepted (in_ready=0).
  - No overflow state is kept.

Test Plan:
- Reset: assert rst mid-clock → d_valid=0, d_out=0000, level=0 and in_ready=1 immediately, before the next edge.
- Single byte: MSB_FIRST=1, out_ready=1, write 8'h3A → d_out=0011 then 1010 on consecutive cycles with d_valid=1, then S_IDLE with d_out=0000 and d_valid=0.
- Back-to-back:
  - Write 8'hAB, 8'hCD, 8'hEF on successive cycles with out_ready=1.
  - d_out must read A,B,C,D,E,F with no d_valid gap.
  - level never exceeds 2.
- Full/backpressure (DEPTH=4):
  - Hold out_ready=0 and write 6 bytes.
  - Byte 1 enters the output stage and bytes 2–5 fill the FIFO, giving level=4 and in_ready=0.
  - Byte 6 is refused; with NIBBLE_SER_OVF_EN, ovf=1.
  - Release out_ready → all 10 nibbles stream in order, and level falls to 0.
- Stall: toggle out_ready 1,0,0,1 during byte 8'h96 → d_out holds 1001 across the stall, then 0110.
- Reset mid-stream: assert rst while level=3 and the FSM is in S_SECOND → outputs return to reset values. After release, a new write of 8'h5C streams 0101, 1100 only, with no stale nibbles.
